// File: rtl/ram_delay_slice.sv
`default_nettype none
// ============================================================================
// Module   : ram_delay_slice
// Purpose  : Single-outstanding request/response slice between a CPU-side
//            memory master and a RAM slave. Pseudo-random stalls are injected
//            on the request path (before issue) and on the response path
//            (extra delay cycles), driven by a 23-bit LFSR (x^23+x^18).
//            stall = lfsr[10] & lfsr[20].
// Ports    : clk, resetn (async, active low), delay_en
//            m_req_*  : master request  (valid/ready, wr, addr, wdata, wstrb)
//            m_rsp_*  : master response (valid/ready, rdata)
//            s_req_*  : RAM request     (valid/ready, wr, addr, wdata, wstrb)
//            s_rsp_*  : RAM response    (valid/ready, rdata)
//            stall_cnt: saturating count of WAIT/RSP_DLY cycles, present
//                       only when the DELAY_STAT_EN macro is defined.
// Config   : `define DELAY_STAT_EN to add the stall_cnt statistics port.
// Revision : 1.0 - initial release
// ============================================================================
module ram_delay_slice #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter logic [22:0] SEED      = 23'h7FFFFF,
  parameter int          MAX_DELAY = 15
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                delay_en,
  input  logic                m_req_valid,
  output logic                m_req_ready,
  input  logic                m_req_wr,
  input  logic [ADDR_W-1:0]   m_req_addr,
  input  logic [DATA_W-1:0]   m_req_wdata,
  input  logic [DATA_W/8-1:0] m_req_wstrb,
  output logic                m_rsp_valid,
  input  logic                m_rsp_ready,
  output logic [DATA_W-1:0]   m_rsp_rdata,
  output logic                s_req_valid,
  input  logic                s_req_ready,
  output logic                s_req_wr,
  output logic [ADDR_W-1:0]   s_req_addr,
  output logic [DATA_W-1:0]   s_req_wdata,
  output logic [DATA_W/8-1:0] s_req_wstrb,
  input  logic                s_rsp_valid,
  output logic                s_rsp_ready,
  input  logic [DATA_W-1:0]   s_rsp_rdata
`ifdef DELAY_STAT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  // An all-zero seed would lock the LFSR; substitute all-ones instead.
  localparam logic [22:0] SEED_EFF = (SEED == 23'd0) ? 23'h7FFFFF : SEED;
  localparam logic [3:0]  MAXD     = 4'(MAX_DELAY);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT     = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_RSP_WAIT = 3'd3,
    ST_RSP_DLY  = 3'd4,
    ST_RSP_OUT  = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [22:0] lfsr;
  logic [3:0]  cnt;
  logic        stall;
  logic        gate_open;
  logic [3:0]  dly_load;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr <= SEED_EFF;
    else         lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
  end

  assign stall     = lfsr[10] & lfsr[20];
  assign gate_open = !delay_en | !stall;
  // Response delay drawn from the low LFSR nibble, clipped to MAX_DELAY.
  assign dly_load  = !delay_en ? 4'd0 : ((lfsr[3:0] > MAXD) ? MAXD : lfsr[3:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    m_req_ready = 1'b0;
    s_req_valid = 1'b0;
    s_rsp_ready = 1'b0;
    m_rsp_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        m_req_ready = 1'b1;
        if (m_req_valid) state_nx = gate_open ? ST_ISSUE : ST_WAIT;
      end
      ST_WAIT: begin
        if (gate_open) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        s_req_valid = 1'b1;
        if (s_req_ready) state_nx = ST_RSP_WAIT;
      end
      ST_RSP_WAIT: begin
        s_rsp_ready = 1'b1;
        if (s_rsp_valid) state_nx = (dly_load == 4'd0) ? ST_RSP_OUT : ST_RSP_DLY;
      end
      ST_RSP_DLY: begin
        // cnt holds the remaining extra cycles including this one.
        if (cnt == 4'd1) state_nx = ST_RSP_OUT;
      end
      ST_RSP_OUT: begin
        m_rsp_valid = 1'b1;
        if (m_rsp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_req_wr    <= 1'b0;
      s_req_addr  <= '0;
      s_req_wdata <= '0;
      s_req_wstrb <= '0;
    end else if (state == ST_IDLE && m_req_valid) begin
      s_req_wr    <= m_req_wr;
      s_req_addr  <= m_req_addr;
      s_req_wdata <= m_req_wdata;
      s_req_wstrb <= m_req_wstrb;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_rsp_rdata <= '0;
      cnt         <= 4'd0;
    end else if (state == ST_RSP_WAIT && s_rsp_valid) begin
      m_rsp_rdata <= s_rsp_rdata;
      cnt         <= dly_load;
    end else if (state == ST_RSP_DLY) begin
      cnt <= cnt - 4'd1;
    end
  end

`ifdef DELAY_STAT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= 32'd0;
    end else if ((state == ST_WAIT || state == ST_RSP_DLY) && stall_cnt != 32'hFFFFFFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_delay_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_delay_slice
// Purpose  : Self-checking bench for ram_delay_slice. Two instances share the
//            stimulus bus: dut_a (MAX_DELAY=15) and dut_b (MAX_DELAY=0);
//            'sel' routes handshakes to one of them, the other idles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_delay_slice;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        delay_en = 1'b0;
  logic        sel = 1'b0;
  logic        m_req_valid = 1'b0, m_req_wr = 1'b0;
  logic [31:0] m_req_addr = '0, m_req_wdata = '0;
  logic [3:0]  m_req_wstrb = '0;
  logic        m_rsp_ready = 1'b0, s_req_ready = 1'b0, s_rsp_valid = 1'b0;
  logic [31:0] s_rsp_rdata = '0;

  logic        a_m_req_ready, a_m_rsp_valid, a_s_req_valid, a_s_req_wr, a_s_rsp_ready;
  logic [31:0] a_m_rsp_rdata, a_s_req_addr, a_s_req_wdata;
  logic [3:0]  a_s_req_wstrb;
  logic        b_m_req_ready, b_m_rsp_valid, b_s_req_valid, b_s_req_wr, b_s_rsp_ready;
  logic [31:0] b_m_rsp_rdata, b_s_req_addr, b_s_req_wdata;
  logic [3:0]  b_s_req_wstrb;
`ifdef DELAY_STAT_EN
  logic [31:0] a_stall_cnt, b_stall_cnt;
`endif

  wire m_req_ready = sel ? b_m_req_ready : a_m_req_ready;
  wire m_rsp_valid = sel ? b_m_rsp_valid : a_m_rsp_valid;
  wire s_req_valid = sel ? b_s_req_valid : a_s_req_valid;
  wire s_rsp_ready = sel ? b_s_rsp_ready : a_s_rsp_ready;
  wire [31:0] m_rsp_rdata = sel ? b_m_rsp_rdata : a_m_rsp_rdata;
  wire [68:0] s_payload = sel ? {b_s_req_wr, b_s_req_addr, b_s_req_wdata, b_s_req_wstrb}
                              : {a_s_req_wr, a_s_req_addr, a_s_req_wdata, a_s_req_wstrb};

  ram_delay_slice #(.ADDR_W(32), .DATA_W(32), .SEED(23'h7FFFFF), .MAX_DELAY(15)) dut_a (
    .clk(clk), .resetn(resetn), .delay_en(delay_en),
    .m_req_valid(m_req_valid & !sel), .m_req_ready(a_m_req_ready), .m_req_wr(m_req_wr),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(a_m_rsp_valid), .m_rsp_ready(m_rsp_ready & !sel), .m_rsp_rdata(a_m_rsp_rdata),
    .s_req_valid(a_s_req_valid), .s_req_ready(s_req_ready & !sel), .s_req_wr(a_s_req_wr),
    .s_req_addr(a_s_req_addr), .s_req_wdata(a_s_req_wdata), .s_req_wstrb(a_s_req_wstrb),
    .s_rsp_valid(s_rsp_valid & !sel), .s_rsp_ready(a_s_rsp_ready), .s_rsp_rdata(s_rsp_rdata)
`ifdef DELAY_STAT_EN
    , .stall_cnt(a_stall_cnt)
`endif
  );

  ram_delay_slice #(.ADDR_W(32), .DATA_W(32), .SEED(23'h7FFFFF), .MAX_DELAY(0)) dut_b (
    .clk(clk), .resetn(resetn), .delay_en(delay_en),
    .m_req_valid(m_req_valid & sel), .m_req_ready(b_m_req_ready), .m_req_wr(m_req_wr),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
    .m_rsp_valid(b_m_rsp_valid), .m_rsp_ready(m_rsp_ready & sel), .m_rsp_rdata(b_m_rsp_rdata),
    .s_req_valid(b_s_req_valid), .s_req_ready(s_req_ready & sel), .s_req_wr(b_s_req_wr),
    .s_req_addr(b_s_req_addr), .s_req_wdata(b_s_req_wdata), .s_req_wstrb(b_s_req_wstrb),
    .s_rsp_valid(s_rsp_valid & sel), .s_rsp_ready(b_s_rsp_ready), .s_rsp_rdata(s_rsp_rdata)
`ifdef DELAY_STAT_EN
    , .stall_cnt(b_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference LFSR and cycle counter; both DUTs share this reset and seed.
  logic [22:0] mlfsr;
  int          cyc = 0;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) mlfsr <= 23'h7FFFFF;
    else         mlfsr <= {mlfsr[21:0], mlfsr[22] ^ mlfsr[17]};
  end
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mism = 0;
  longint exp_stall [2];
  logic [68:0] req_q [$];
  logic [31:0] rsp_q [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Number of consecutive stalled cycles starting from LFSR state l.
  function automatic int stalled_run(input logic [22:0] l);
    int w = 0;
    logic [22:0] v = l;
    while (v[10] && v[20] && w < 10000) begin
      w++;
      v = {v[21:0], v[22] ^ v[17]};
    end
    return w;
  endfunction

  task automatic do_reset(input string tag);
    resetn = 1'b0;
    m_req_valid = 1'b0; s_req_ready = 1'b0; s_rsp_valid = 1'b0; m_rsp_ready = 1'b0;
    req_q.delete(); rsp_q.delete();
    exp_stall[0] = 0; exp_stall[1] = 0;
    #1;
    compared++;
    if ({m_req_ready, s_req_valid, s_rsp_ready, m_rsp_valid} !== 4'b1000 ||
        s_payload !== 69'd0 || m_rsp_rdata !== 32'd0) begin
      mism++;
      $display("FAIL %s: rdy/sv/sr/mv=%b payload=%h rdata=%h, required 1000/0/0", tag,
               {m_req_ready, s_req_valid, s_rsp_ready, m_rsp_valid}, s_payload, m_rsp_rdata);
    end
    step();
    step();
    resetn = 1'b1;
  endtask

  // One full transaction on the selected DUT, checked cycle by cycle.
  task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [31:0] rd, input int ram_lat,
                     input int issue_hold, input int rsp_hold, input bit pend, input int fixed_lat);
    int t, u, n, w, cexp;
    logic [68:0] ep;
    logic [31:0] er;
    logic [3:0]  maxd;
    maxd = sel ? 4'd0 : 4'd15;
    compared++;
    if (m_req_ready !== 1'b1) begin
      mism++; $display("FAIL req_ready_idle: got %b, required 1", m_req_ready);
    end
    m_req_valid = 1'b1; m_req_wr = wr; m_req_addr = a; m_req_wdata = wd; m_req_wstrb = ws;
    req_q.push_back({wr, a, wd, ws});
    w = delay_en ? stalled_run(mlfsr) : 0;
    t = cyc;
    step();
    m_req_valid = 1'b0;
    n = 0;
    while (s_req_valid !== 1'b1 && n < 300) begin step(); n++; end
    compared++;
    if (s_req_valid !== 1'b1) begin
      mism++; $display("FAIL req_timeout: s_req_valid=%b, required 1", s_req_valid);
      return;
    end
    compared++;
    if (cyc - t !== 1 + w) begin
      mism++; $display("FAIL req_latency: got %0d, required %0d", cyc - t, 1 + w);
    end
    if (fixed_lat >= 0) begin
      compared++;
      if (cyc - t !== fixed_lat) begin
        mism++; $display("FAIL req_first_issue: got %0d, required %0d", cyc - t, fixed_lat);
      end
    end
    ep = req_q.pop_front();
    for (int i = 0; i < issue_hold; i++) begin
      compared++;
      if (s_req_valid !== 1'b1 || m_req_ready !== 1'b0 || s_payload !== ep) begin
        mism++;
        $display("FAIL issue_hold: sv=%b rdy=%b payload=%h, required 1/0/%h",
                 s_req_valid, m_req_ready, s_payload, ep);
      end
      step();
    end
    s_req_ready = 1'b1;
    compared++;
    if (s_payload !== ep || s_req_valid !== 1'b1) begin
      mism++; $display("FAIL req_payload: got %h sv=%b, required %h", s_payload, s_req_valid, ep);
    end
    step();
    s_req_ready = 1'b0;
    for (int i = 0; i < ram_lat; i++) step();
    s_rsp_valid = 1'b1; s_rsp_rdata = rd;
    rsp_q.push_back(rd);
    compared++;
    if (s_rsp_ready !== 1'b1 || s_req_valid !== 1'b0) begin
      mism++; $display("FAIL rsp_wait: s_rsp_ready=%b s_req_valid=%b, required 1/0", s_rsp_ready, s_req_valid);
    end
    cexp = !delay_en ? 0 : ((mlfsr[3:0] > maxd) ? int'(maxd) : int'(mlfsr[3:0]));
    exp_stall[sel] += longint'(w + cexp);
    u = cyc;
    step();
    s_rsp_valid = 1'b0; s_rsp_rdata = $urandom;
    n = 0;
    while (m_rsp_valid !== 1'b1 && n < 300) begin step(); n++; end
    compared++;
    if (m_rsp_valid !== 1'b1) begin
      mism++; $display("FAIL rsp_timeout: m_rsp_valid=%b, required 1", m_rsp_valid);
      return;
    end
    compared++;
    if (cyc - u !== 1 + cexp) begin
      mism++; $display("FAIL rsp_latency: got %0d, required %0d", cyc - u, 1 + cexp);
    end
    er = rsp_q.pop_front();
    for (int i = 0; i < rsp_hold; i++) begin
      if (pend) begin
        m_req_valid = 1'b1; m_req_addr = $urandom;
      end
      compared++;
      if (m_rsp_valid !== 1'b1 || m_rsp_rdata !== er || m_req_ready !== 1'b0) begin
        mism++;
        $display("FAIL rsp_hold: mv=%b rdata=%h rdy=%b, required 1/%h/0", m_rsp_valid, m_rsp_rdata, m_req_ready, er);
      end
      step();
    end
    m_rsp_ready = 1'b1;
    compared++;
    if (m_rsp_rdata !== er) begin
      mism++; $display("FAIL rsp_data: got %h, required %h", m_rsp_rdata, er);
    end
    step();
    m_rsp_ready = 1'b0;
    m_req_valid = 1'b0;
    compared++;
    if (m_rsp_valid !== 1'b0 || s_req_valid !== 1'b0 || m_req_ready !== 1'b1) begin
      mism++;
      $display("FAIL back_to_idle: mv=%b sv=%b rdy=%b, required 0/0/1", m_rsp_valid, s_req_valid, m_req_ready);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    do_reset("reset_values");
  endtask

  task automatic test_basic_read();
    delay_en = 1'b0;
    txn(1'b0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 1'b0, 1);
    txn(1'b1, 32'h204, 32'hCAFEF00D, 4'h5, 32'h13572468, 1, 0, 0, 1'b0, 1);
  endtask

  task automatic test_lfsr_stall();
    do_reset("reset_before_lfsr");
    delay_en = 1'b1;
    // All-ones seed keeps the gate shut for 11 cycles: ISSUE in cycle 12.
    txn(1'b0, 32'h40, 32'h0, 4'hF, 32'h11112222, 0, 0, 0, 1'b0, 12);
    for (int k = 0; k < 1000; k++) begin
      txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), $urandom,
          $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, -1);
    end
`ifdef DELAY_STAT_EN
    compared++;
    if (a_stall_cnt !== 32'(exp_stall[0])) begin
      mism++; $display("FAIL stall_cnt_a: got %0d, required %0d", a_stall_cnt, exp_stall[0]);
    end
`endif
  endtask

  task automatic test_issue_hold();
    delay_en = 1'b0;
    txn(1'b1, 32'hA5A5_0000, 32'h0BAD_F00D, 4'h3, 32'h99, 0, 5, 0, 1'b0, 1);
  endtask

  task automatic test_rsp_backpressure();
    delay_en = 1'b0;
    txn(1'b0, 32'h300, 32'h0, 4'hF, 32'h5A5AA5A5, 0, 0, 3, 1'b1, 1);
  endtask

  task automatic test_reset_mid_delay();
    int n;
    delay_en = 1'b1;
    m_req_valid = 1'b1; m_req_addr = 32'h500; m_req_wr = 1'b0;
    step();
    m_req_valid = 1'b0;
    n = 0;
    while (s_req_valid !== 1'b1 && n < 300) begin step(); n++; end
    s_req_ready = 1'b1;
    step();
    s_req_ready = 1'b0;
    n = 0;
    while (mlfsr[3:0] < 4'd2 && n < 300) begin step(); n++; end
    s_rsp_valid = 1'b1; s_rsp_rdata = 32'h7777_8888;
    step();
    s_rsp_valid = 1'b0;
    compared++;
    if (m_rsp_valid !== 1'b0 || s_rsp_ready !== 1'b0 || m_req_ready !== 1'b0) begin
      mism++;
      $display("FAIL in_rsp_dly: mv=%b sr=%b rdy=%b, required 0/0/0", m_rsp_valid, s_rsp_ready, m_req_ready);
    end
    #2;
    do_reset("reset_mid_dly");
    delay_en = 1'b0;
    txn(1'b0, 32'h504, 32'h0, 4'hF, 32'h2468ACE0, 0, 0, 0, 1'b0, 1);
  endtask

  task automatic test_max_delay_zero();
    do_reset("reset_before_maxd0");
    sel = 1'b1;
    delay_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      txn(1'b0, $urandom, $urandom, 4'hF, $urandom, 0, 0, 0, 1'b0, -1);
    end
`ifdef DELAY_STAT_EN
    compared++;
    if (b_stall_cnt !== 32'(exp_stall[1])) begin
      mism++; $display("FAIL stall_cnt_b: got %0d, required %0d", b_stall_cnt, exp_stall[1]);
    end
    compared++;
    if (a_stall_cnt !== 32'd0) begin
      mism++; $display("FAIL stall_cnt_idle: got %0d, required 0", a_stall_cnt);
    end
`endif
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_lfsr_stall();
    test_issue_hold();
    test_rsp_backpressure();
    test_reset_mid_delay();
    test_max_delay_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
`default_nettype wire
